// File: rtl/mem_access_ctrl.sv
// Single-port RAM access sequencer: arbitrates fetch (IF) and load/store (LS) requests
// onto one negedge-clocked RAM. Optional address bounds check: define MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_WORDS = 9
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_IF_REQ,
    input  logic [ADDR_W-1:0] I_IF_ADDR,
    output logic              O_IF_GNT,
    output logic              O_IF_RVALID,
    output logic [DATA_W-1:0] O_IF_RDATA,
    output logic              O_IF_ERR,
    input  logic              I_LS_REQ,
    input  logic              I_LS_WE,
    input  logic [ADDR_W-1:0] I_LS_ADDR,
    input  logic [DATA_W-1:0] I_LS_WDATA,
    output logic              O_LS_GNT,
    output logic              O_LS_RVALID,
    output logic [DATA_W-1:0] O_LS_RDATA,
    output logic              O_LS_ERR,
    output logic              O_RAM_WE,
    output logic [ADDR_W-1:0] O_RAM_ADDR,
    output logic [DATA_W-1:0] O_RAM_WDATA,
    input  logic [DATA_W-1:0] I_RAM_RDATA,
    output logic              O_BUSY
);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic              issue_if;
    logic              issue_ls;
    logic              issue;
    logic              issue_oob;
    logic [ADDR_W-1:0] issue_addr;
    logic              store_q;
    logic              oob_q;

    always_comb begin
        state_nxt = state;
        issue_if  = 1'b0;
        issue_ls  = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                // Grants are suppressed while reset is held so every output reads 0.
                if (I_RST_N && I_LS_REQ) begin
                    issue_ls = 1'b1;
                end else if (I_RST_N && I_IF_REQ) begin
                    issue_if = 1'b1;
                end
                state_nxt = (issue_ls || issue_if) ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: state_nxt = ST_RESP;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign issue      = issue_if | issue_ls;
    assign issue_addr = issue_ls ? I_LS_ADDR : I_IF_ADDR;
    assign issue_oob  = BOUNDS_EN && ({1'b0, issue_addr} >= MEM_LIMIT);

    assign O_IF_GNT    = issue_if;
    assign O_LS_GNT    = issue_ls;
    assign O_IF_RVALID = (state == ST_RESP) && (owner == OWN_IF);
    assign O_LS_RVALID = (state == ST_RESP) && (owner == OWN_LS);
    assign O_BUSY      = (state != ST_IDLE);

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            owner       <= OWN_IF;
            store_q     <= 1'b0;
            oob_q       <= 1'b0;
            O_RAM_WE    <= 1'b0;
            O_RAM_ADDR  <= '0;
            O_RAM_WDATA <= '0;
            O_IF_RDATA  <= '0;
            O_LS_RDATA  <= '0;
            O_IF_ERR    <= 1'b0;
            O_LS_ERR    <= 1'b0;
        end else if (issue) begin
            owner      <= issue_ls ? OWN_LS : OWN_IF;
            store_q    <= issue_ls && I_LS_WE;
            oob_q      <= issue_oob;
            O_RAM_ADDR <= issue_addr;
            if (issue_ls) begin
                O_RAM_WDATA <= I_LS_WDATA;
            end
            O_RAM_WE <= issue_ls && I_LS_WE && !issue_oob;
        end else if (state == ST_ACCESS) begin
            // WE must be low before the falling edge of RESP/IDLE; the RAM writes on every low edge.
            O_RAM_WE <= 1'b0;
            if (owner == OWN_LS) begin
                if (oob_q) begin
                    O_LS_RDATA <= '0;
                end else if (!store_q) begin
                    O_LS_RDATA <= I_RAM_RDATA;
                end
                O_LS_ERR <= oob_q;
            end else begin
                O_IF_RDATA <= oob_q ? '0 : I_RAM_RDATA;
                O_IF_ERR   <= oob_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: negedge RAM model, transaction-level reference model,
// per-cycle output comparison, directed cases plus randomized traffic.
module tb_mem_access_ctrl;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned MW = 9;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit TB_BOUNDS = 1'b1;
`else
    localparam bit TB_BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, if_err;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_rvalid, ls_err;
    logic [DW-1:0] ls_rdata;
    logic          ram_we, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)) dut (
        .I_CLK(clk), .I_RST_N(rst_n),
        .I_IF_REQ(if_req), .I_IF_ADDR(if_addr), .O_IF_GNT(if_gnt), .O_IF_RVALID(if_rvalid),
        .O_IF_RDATA(if_rdata), .O_IF_ERR(if_err),
        .I_LS_REQ(ls_req), .I_LS_WE(ls_we), .I_LS_ADDR(ls_addr), .I_LS_WDATA(ls_wdata),
        .O_LS_GNT(ls_gnt), .O_LS_RVALID(ls_rvalid), .O_LS_RDATA(ls_rdata), .O_LS_ERR(ls_err),
        .O_RAM_WE(ram_we), .O_RAM_ADDR(ram_addr), .O_RAM_WDATA(ram_wdata),
        .I_RAM_RDATA(ram_rdata), .O_BUSY(busy)
    );

    function automatic logic [DW-1:0] init_word(input int unsigned i);
        if (i == 0) return 16'h80FE;
        return 16'h1000 + 16'(i);
    endfunction

    // RAM: reads and writes on the falling edge, returning the old word on a write edge.
    logic [DW-1:0] ram [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        forever begin
            @(negedge clk);
            ram_rdata <= ram[ram_addr[7:0]];
            if (ram_we) ram[ram_addr[7:0]] = ram_wdata;
        end
    end

    typedef struct {int due; bit is_ls; bit is_store; bit oob; logic [AW-1:0] addr; logic [DW-1:0] wdata;} acc_t;
    typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} lsop_t;
    typedef struct {int at; bit is_ls; logic [DW-1:0] data; bit err;} ev_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_gnt = -100;
    int rst_cnt = 0;
    int we_cycles = 0;
    int busy_cycles = 0;
    bit rnd_mode = 1'b0;
    bit if_pend = 1'b0;
    bit ls_pend = 1'b0;
    acc_t fl[$];
    lsop_t lsq[$];
    logic [AW-1:0] ifq[$];
    ev_t resp_log[$];
    ev_t gnt_log[$];
    logic [DW-1:0] mmem [0:255];
    logic [DW-1:0] e_if_rdata = '0;
    logic [DW-1:0] e_ls_rdata = '0;
    bit e_if_err = 1'b0;
    bit e_ls_err = 1'b0;

    function automatic bit out_of_range(input logic [AW-1:0] a);
        return TB_BOUNDS && (a >= AW'(MW));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: one access at a time, grants at least 2 cycles apart, response exactly
    // 2 cycles after the grant cycle, RAM write strobe in the cycle between.
    task automatic evaluate();
        bit e_gnt_if, e_gnt_ls, e_rv_if, e_rv_ls, e_we, e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, d;
        acc_t r;
        e_gnt_if = 0; e_gnt_ls = 0; e_rv_if = 0; e_rv_ls = 0; e_we = 0; e_busy = 0;
        e_addr = '0; e_wdata = '0;
        if (!rst_n) begin
            fl.delete();
            last_gnt = -100;
            e_if_rdata = '0; e_ls_rdata = '0; e_if_err = 0; e_ls_err = 0;
            if_pend = 0; ls_pend = 0;
        end else begin
            if (fl.size() > 0 && fl[0].due == cyc) begin
                r = fl.pop_front();
                d = r.oob ? '0 : mmem[r.addr[7:0]];
                if (r.is_store && !r.oob) mmem[r.addr[7:0]] = r.wdata;
                if (r.is_ls) begin
                    e_rv_ls = 1; e_ls_err = r.oob;
                    if (!r.is_store || r.oob) e_ls_rdata = d;
                end else begin
                    e_rv_if = 1; e_if_err = r.oob; e_if_rdata = d;
                end
            end
            e_busy = e_rv_if || e_rv_ls || (fl.size() > 0);
            if (fl.size() > 0 && fl[0].is_store && !fl[0].oob) begin
                e_we = 1; e_addr = fl[0].addr; e_wdata = fl[0].wdata;
            end
            e_gnt_ls = (cyc - last_gnt >= 2) && ls_req;
            e_gnt_if = (cyc - last_gnt >= 2) && !ls_req && if_req;
        end
        chk("if_gnt", 32'(if_gnt), 32'(e_gnt_if));
        chk("ls_gnt", 32'(ls_gnt), 32'(e_gnt_ls));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_rv_if));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(e_rv_ls));
        chk("if_rdata", 32'(if_rdata), 32'(e_if_rdata));
        chk("ls_rdata", 32'(ls_rdata), 32'(e_ls_rdata));
        chk("if_err", 32'(if_err), 32'(e_if_err));
        chk("ls_err", 32'(ls_err), 32'(e_ls_err));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_we || !rst_n) begin
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        end
        if (if_rvalid) resp_log.push_back('{cyc, 1'b0, if_rdata, if_err});
        if (ls_rvalid) resp_log.push_back('{cyc, 1'b1, ls_rdata, ls_err});
        if (if_gnt) gnt_log.push_back('{cyc, 1'b0, '0, 1'b0});
        if (ls_gnt) gnt_log.push_back('{cyc, 1'b1, '0, 1'b0});
        if (ram_we) we_cycles++;
        if (busy) busy_cycles++;
        if (e_gnt_ls) begin
            fl.push_back('{cyc + 2, 1'b1, ls_we, out_of_range(ls_addr), ls_addr, ls_wdata});
            last_gnt = cyc; ls_pend = 0;
        end else if (e_gnt_if) begin
            fl.push_back('{cyc + 2, 1'b0, 1'b0, out_of_range(if_addr), if_addr, '0});
            last_gnt = cyc; if_pend = 0;
        end
    endtask

    task automatic step();
        lsop_t op;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_cnt > 0) begin
            rst_n = 1'b0; rst_cnt--;
        end else begin
            rst_n = 1'b1;
        end
        if (!ls_pend) ls_req = 1'b0;
        if (!if_pend) if_req = 1'b0;
        if (!ls_pend && lsq.size() > 0 && (!rnd_mode || $urandom_range(2, 0) != 0)) begin
            op = lsq.pop_front();
            ls_req = 1'b1; ls_we = op.we; ls_addr = op.addr; ls_wdata = op.wdata; ls_pend = 1;
        end else if (ls_pend && rnd_mode && $urandom_range(15, 0) == 0) begin
            ls_req = 1'b0; ls_pend = 0;
        end else if (ls_pend && rnd_mode && $urandom_range(7, 0) == 0) begin
            ls_we = 1'($urandom_range(1, 0));
            ls_addr = AW'($urandom_range(15, 0));
            ls_wdata = DW'($urandom);
        end
        if (!if_pend && ifq.size() > 0 && (!rnd_mode || $urandom_range(2, 0) != 0)) begin
            if_addr = ifq.pop_front(); if_req = 1'b1; if_pend = 1;
        end
        @(negedge clk);
        evaluate();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((lsq.size() > 0 || ifq.size() > 0 || ls_pend || if_pend || fl.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
        step();
    endtask

    task automatic clear_logs();
        resp_log.delete(); gnt_log.delete(); we_cycles = 0; busy_cycles = 0;
    endtask

    initial begin
        logic [DW-1:0] b2b_exp [4];
        int n;
        b2b_exp = '{16'h80FE, 16'h1001, 16'h1002, 16'h1003};
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
        rst_cnt = 3;
        repeat (5) step();

        clear_logs();
        ifq.push_back(16'h0000);
        drain(40);
        chk("fetch_count", 32'(resp_log.size()), 32'd1);
        if (resp_log.size() == 1 && gnt_log.size() == 1) begin
            chk("fetch_data", 32'(resp_log[0].data), 32'h80FE);
            chk("fetch_latency", 32'(resp_log[0].at - gnt_log[0].at), 32'd2);
        end
        chk("fetch_no_we", 32'(we_cycles), 32'd0);

        clear_logs();
        lsq.push_back('{1'b1, 16'd7, 16'hA5A5});
        lsq.push_back('{1'b0, 16'd7, 16'h0000});
        drain(40);
        chk("st_ld_count", 32'(resp_log.size()), 32'd2);
        if (resp_log.size() == 2) begin
            chk("store_rdata_held", 32'(resp_log[0].data), 32'h0000);
            chk("load_data", 32'(resp_log[1].data), 32'hA5A5);
        end
        chk("store_we_cycles", 32'(we_cycles), 32'd1);

        clear_logs();
        ifq.push_back(16'd1);
        lsq.push_back('{1'b0, 16'd2, 16'h0000});
        drain(40);
        chk("cont_count", 32'(resp_log.size()), 32'd2);
        if (resp_log.size() == 2 && gnt_log.size() == 2) begin
            chk("cont_first_ls", 32'(resp_log[0].is_ls), 32'd1);
            chk("cont_ls_data", 32'(resp_log[0].data), 32'h1002);
            chk("cont_if_data", 32'(resp_log[1].data), 32'h1001);
            chk("cont_gnt_gap", 32'(gnt_log[1].at - gnt_log[0].at), 32'd2);
        end

        clear_logs();
        lsq.push_back('{1'b1, 16'd8, 16'h1234});
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin
            step();
            n++;
        end
        chk("rst_store_granted", 32'(gnt_log.size()), 32'd1);
        rst_cnt = 2;
        step();
        chk("rst_ctrl_zero", 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_we, busy, if_err, ls_err}), 32'd0);
        chk("rst_rdata_zero", {if_rdata, ls_rdata}, 32'd0);
        repeat (4) step();
        chk("rst_no_resp", 32'(resp_log.size()), 32'd0);
        chk("rst_mem8_kept", 32'(ram[8]), 32'h1008);

        clear_logs();
        for (int i = 0; i < 4; i++) ifq.push_back(AW'(i));
        drain(60);
        chk("b2b_count", 32'(resp_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < resp_log.size()) begin
                chk("b2b_data", 32'(resp_log[i].data), 32'(b2b_exp[i]));
                if (i > 0) chk("b2b_gap", 32'(resp_log[i].at - resp_log[i-1].at), 32'd2);
            end
        end
        chk("b2b_busy_cycles", 32'(busy_cycles), 32'd8);

`ifdef MEM_BOUNDS_CHECK_EN
        clear_logs();
        lsq.push_back('{1'b1, 16'd9, 16'hBEEF});
        lsq.push_back('{1'b0, 16'd9, 16'h0000});
        drain(40);
        chk("oob_count", 32'(resp_log.size()), 32'd2);
        if (resp_log.size() == 2) begin
            chk("oob_store_err", 32'(resp_log[0].err), 32'd1);
            chk("oob_load_data", 32'(resp_log[1].data), 32'h0000);
            chk("oob_load_err", 32'(resp_log[1].err), 32'd1);
        end
        chk("oob_no_we", 32'(we_cycles), 32'd0);
`endif

        rnd_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            lsq.push_back('{1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), DW'($urandom)});
            ifq.push_back(AW'($urandom_range(15, 0)));
        end
        drain(5000);
        rnd_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
